// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the rst_seq reset sequencer.
// Holds the FSM state enum, the cause bit positions and a parameter helper.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_POR       = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_ASSERT    = 3'd4,
        ST_HOLD      = 3'd5
    } rst_seq_state_e;

    localparam int CausePor  = 0;
    localparam int CauseLock = 1;
    localparam int CauseSw   = 2;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/rst_seq_filt.sv
// Consecutive-high filter: stable_o is high once in_i has been sampled high
// for Cycles edges in a row; any low sample or clr_i restarts the count.
module rst_seq_filt #(
    parameter int Cycles = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic in_i,
    output logic stable_o
);

    localparam int CntW = $clog2(Cycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(Cycles);

    logic [CntW-1:0] r_cnt;

    // Run-length counter, saturating at Cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i || !in_i) begin
            r_cnt <= '0;
        end else if (r_cnt != CntMax) begin
            r_cnt <= r_cnt + CntW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign stable_o = (r_cnt == CntMax);

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds channel resets through POR and lock filtering, releases
// them in order, tears them down in reverse on request. Optional cause register
// enabled by defining RST_SEQ_CAUSE_EN.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NumResets  = 4,
    parameter int PorCycles  = 16,
    parameter int LockFilter = 8,
    parameter int StageDelay = 8,
    parameter int HoldCycles = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 locked_i,
    input  logic                 sw_rst_req_i,
    input  logic                 cause_clr_i,
    output logic [NumResets-1:0] rst_n_o,
    output logic                 done_o,
    output logic [2:0]           cause_o
);

    localparam int CntMax = max4(PorCycles, LockFilter, StageDelay, HoldCycles);
    localparam int CntW   = $clog2(CntMax + 1);
    localparam int IdxW   = (NumResets > 1) ? $clog2(NumResets) : 1;

    localparam logic [CntW-1:0] CntSat    = CntW'(CntMax);
    localparam logic [CntW-1:0] PorLast   = CntW'(PorCycles - 1);
    localparam logic [CntW-1:0] StageLast = CntW'(StageDelay - 1);
    localparam logic [CntW-1:0] HoldLast  = CntW'(HoldCycles - 1);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(NumResets - 1);
    localparam logic [IdxW-1:0] IdxPrev   = IdxW'((NumResets > 1) ? NumResets - 2 : 0);

    rst_seq_state_e        r_state, w_state_nx;
    logic [CntW-1:0]       r_cnt, w_cnt_nx;
    logic [IdxW-1:0]       r_idx, w_idx_nx;
    logic [NumResets-1:0]  r_rst_n, w_rst_n_nx;
    logic                  r_done, w_done_nx;
    logic [2:0]            w_cause_set;
    logic                  w_lock_lost;
    logic                  w_stable;

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (v == CntSat) ? v : v + CntW'(1);
    endfunction

    rst_seq_filt #(
        .Cycles (LockFilter)
    ) u_lock_filt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (r_state != ST_WAIT_LOCK),
        .in_i     (locked_i),
        .stable_o (w_stable)
    );

    // Next-state, counter, index and output computation.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_idx_nx    = r_idx;
        w_rst_n_nx  = r_rst_n;
        w_done_nx   = r_done;
        w_cause_set = 3'b000;
        w_lock_lost = !locked_i && ((r_state == ST_RELEASE) || (r_state == ST_RUN) ||
                                    (r_state == ST_ASSERT)  || (r_state == ST_HOLD));

        // Lock loss overrides any stage step or software request this cycle.
        if (w_lock_lost) begin
            w_state_nx             = ST_WAIT_LOCK;
            w_cnt_nx               = '0;
            w_idx_nx               = '0;
            w_rst_n_nx             = '0;
            w_done_nx              = 1'b0;
            w_cause_set[CauseLock] = 1'b1;
        end else begin
            case (r_state)
                ST_POR: begin
                    if (r_cnt == PorLast) begin
                        w_state_nx = ST_WAIT_LOCK;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = sat_inc(r_cnt);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_stable && locked_i) begin
                        w_state_nx = ST_RELEASE;
                        w_cnt_nx   = '0;
                        w_idx_nx   = '0;
                    end else begin
                        w_cnt_nx = '0;
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == StageLast) begin
                        w_rst_n_nx[r_idx] = 1'b1;
                        w_cnt_nx          = '0;
                        if (r_idx == IdxLast) begin
                            w_state_nx = ST_RUN;
                            w_done_nx  = 1'b1;
                            w_idx_nx   = '0;
                        end else begin
                            w_idx_nx = r_idx + IdxW'(1);
                        end
                    end else begin
                        w_cnt_nx = sat_inc(r_cnt);
                    end
                end
                ST_RUN: begin
                    if (sw_rst_req_i) begin
                        w_cause_set[CauseSw]     = 1'b1;
                        w_rst_n_nx[NumResets-1]  = 1'b0;
                        w_done_nx                = 1'b0;
                        w_cnt_nx                 = '0;
                        w_idx_nx                 = IdxPrev;
                        if (NumResets == 1) begin
                            w_state_nx = ST_HOLD;
                        end else begin
                            w_state_nx = ST_ASSERT;
                        end
                    end else begin
                        w_done_nx = 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (r_cnt == StageLast) begin
                        w_rst_n_nx[r_idx] = 1'b0;
                        w_cnt_nx          = '0;
                        if (r_idx == '0) begin
                            w_state_nx = ST_HOLD;
                        end else begin
                            w_idx_nx = r_idx - IdxW'(1);
                        end
                    end else begin
                        w_cnt_nx = sat_inc(r_cnt);
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == HoldLast) begin
                        w_state_nx = ST_WAIT_LOCK;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = sat_inc(r_cnt);
                    end
                end
                default: begin
                    w_state_nx = ST_POR;
                    w_cnt_nx   = '0;
                    w_idx_nx   = '0;
                    w_rst_n_nx = '0;
                    w_done_nx  = 1'b0;
                end
            endcase
        end
    end

    // State and registered output update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_POR;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst_n <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_rst_n <= w_rst_n_nx;
            r_done  <= w_done_nx;
        end
    end

    assign rst_n_o = r_rst_n;
    assign done_o  = r_done;

`ifdef RST_SEQ_CAUSE_EN
    logic [2:0] r_cause;

    // Sticky cause bits; an event coinciding with a clear survives the clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cause <= 3'b001;
        end else if (cause_clr_i) begin
            r_cause <= w_cause_set;
        end else begin
            r_cause <= r_cause | w_cause_set;
        end
    end

    assign cause_o = r_cause;
`else
    logic w_unused;
    assign w_unused = ^{cause_clr_i, w_cause_set};
    assign cause_o  = 3'b000;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: a cycle-level behavioural model compared on
// every falling edge, plus hand-computed literal checkpoints.
module tb_rst_seq;

    localparam int N  = 4;
    localparam int PC = 16;
    localparam int LF = 8;
    localparam int SD = 8;
    localparam int HC = 32;
`ifdef RST_SEQ_CAUSE_EN
    localparam bit CauseEn = 1'b1;
`else
    localparam bit CauseEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         locked_i = 1'b0;
    logic         sw_rst_req_i = 1'b0;
    logic         cause_clr_i = 1'b0;
    logic [N-1:0] rst_n_o;
    logic         done_o;
    logic [2:0]   cause_o;

    int n_chk = 0;
    int n_err = 0;

    rst_seq #(
        .NumResets  (N),
        .PorCycles  (PC),
        .LockFilter (LF),
        .StageDelay (SD),
        .HoldCycles (HC)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .locked_i     (locked_i),
        .sw_rst_req_i (sw_rst_req_i),
        .cause_clr_i  (cause_clr_i),
        .rst_n_o      (rst_n_o),
        .done_o       (done_o),
        .cause_o      (cause_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Inputs as seen by the posedge
    logic s_rst = 1'b1, s_lk = 1'b0, s_sw = 1'b0, s_clr = 1'b0;
    logic armed = 1'b0;
    always @(posedge clk) begin
        s_rst <= rst_i;
        s_lk  <= locked_i;
        s_sw  <= sw_rst_req_i;
        s_clr <= cause_clr_i;
        if (rst_i) armed <= 1'b1;
    end

    // Model: phase 0 POR, 1 WAIT, 2 RELEASE, 3 RUN, 4 ASSERT, 5 HOLD.
    // m_on = number of low-order channels currently released.
    int       m_ph = 0, m_e = 0, m_run = 0, m_on = 0;
    bit [2:0] m_cause = 3'b001;

    task automatic model_step(input bit rst, input bit lk, input bit sw, input bit clr);
        bit [2:0] set;
        set = 3'b000;
        if (rst) begin
            m_ph = 0; m_e = 0; m_on = 0; m_run = 0; m_cause = 3'b001;
        end else begin
            if (m_ph >= 2 && !lk) begin
                m_ph = 1; m_on = 0; m_run = 0; set[1] = 1'b1;
            end else begin
                case (m_ph)
                    0: begin
                        m_e++;
                        if (m_e == PC) begin m_ph = 1; m_run = 0; end
                    end
                    1: begin
                        if (m_run >= LF && lk) begin m_ph = 2; m_e = 0; end
                        else m_run = lk ? m_run + 1 : 0;
                    end
                    2: begin
                        m_e++;
                        m_on = m_e / SD;
                        if (m_on == N) m_ph = 3;
                    end
                    3: begin
                        if (sw) begin
                            set[2] = 1'b1; m_e = 0; m_on = N - 1;
                            m_ph = (m_on == 0) ? 5 : 4;
                        end
                    end
                    4: begin
                        m_e++;
                        m_on = N - 1 - m_e / SD;
                        if (m_on == 0) begin m_ph = 5; m_e = 0; end
                    end
                    default: begin
                        m_e++;
                        if (m_e == HC) begin m_ph = 1; m_run = 0; end
                    end
                endcase
            end
            m_cause = clr ? set : (m_cause | set);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            model_step(s_rst, s_lk, s_sw, s_clr);
            chk("rst_n", int'(rst_n_o), (1 << m_on) - 1);
            chk("done", int'(done_o), (m_ph == 3) ? 1 : 0);
            chk("cause", int'(cause_o), CauseEn ? int'(m_cause) : 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int cz(input int v);
        return CauseEn ? v : 0;
    endfunction

    initial begin
        // Reset state, then default power-up sequence with lock high.
        locked_i = 1'b1;
        step(3);
        chk("lit_reset_rst_n", int'(rst_n_o), 0);
        chk("lit_reset_cause", int'(cause_o), cz(1));
        rst_i = 1'b0;
        step(32);
        chk("lit_c31", int'(rst_n_o), 4'b0000);
        step(1);
        chk("lit_c32", int'(rst_n_o), 4'b0001);
        step(7);
        chk("lit_c39", int'(rst_n_o), 4'b0001);
        step(1);
        chk("lit_c40", int'(rst_n_o), 4'b0011);
        step(8);
        chk("lit_c48", int'(rst_n_o), 4'b0111);
        step(7);
        chk("lit_c55_done", int'(done_o), 0);
        step(1);
        chk("lit_c56", int'(rst_n_o), 4'b1111);
        chk("lit_c56_done", int'(done_o), 1);
        chk("lit_c56_cause", int'(cause_o), cz(1));

        // Software teardown, an ignored request during ASSERT, hold and re-release.
        step(5);
        sw_rst_req_i = 1'b1; step(1); sw_rst_req_i = 1'b0;
        chk("lit_sw_n", int'(rst_n_o), 4'b0111);
        step(7);
        chk("lit_sw_n7", int'(rst_n_o), 4'b0111);
        step(1);
        chk("lit_sw_n8", int'(rst_n_o), 4'b0011);
        sw_rst_req_i = 1'b1; step(1); sw_rst_req_i = 1'b0;
        step(15);
        chk("lit_sw_n24", int'(rst_n_o), 4'b0000);
        step(110);
        chk("lit_sw_rerun", int'(rst_n_o), 4'b1111);
        chk("lit_sw_cause", int'(cause_o), cz(5));

        // Lock loss in RUN, clear causes, relock, then lose lock during RELEASE.
        locked_i = 1'b0; step(1);
        chk("lit_ll_run", int'(rst_n_o), 0);
        locked_i = 1'b1; cause_clr_i = 1'b1; step(1); cause_clr_i = 1'b0;
        step(26);
        chk("lit_rel_0011", int'(rst_n_o), 4'b0011);
        locked_i = 1'b0; step(1);
        chk("lit_ll_rel", int'(rst_n_o), 0);
        chk("lit_ll_rel_done", int'(done_o), 0);
        chk("lit_ll_rel_cause", int'(cause_o), cz(2));

        // Glitchy lock during WAIT_LOCK never releases.
        for (int r = 0; r < 4; r++) begin
            locked_i = 1'b1; step(4);
            locked_i = 1'b0; step(1);
        end
        chk("lit_glitch", int'(rst_n_o), 0);
        locked_i = 1'b1;
        step(16);
        chk("lit_filt_15", int'(rst_n_o), 4'b0000);
        step(1);
        chk("lit_filt_16", int'(rst_n_o), 4'b0001);
        step(50);

        // Software request and lock loss in the same RUN cycle.
        sw_rst_req_i = 1'b1; locked_i = 1'b0; step(1);
        sw_rst_req_i = 1'b0; locked_i = 1'b1;
        chk("lit_both_n", int'(rst_n_o), 0);
        chk("lit_both_done", int'(done_o), 0);
        chk("lit_both_cause", int'(cause_o), cz(2));
        step(45);
        chk("lit_both_rerun", int'(rst_n_o), 4'b1111);

        // Cause clear coinciding with lock loss keeps only the lock bit.
        sw_rst_req_i = 1'b1; step(1); sw_rst_req_i = 1'b0;
        step(3);
        cause_clr_i = 1'b1; locked_i = 1'b0; step(1);
        cause_clr_i = 1'b0; locked_i = 1'b1;
        chk("lit_clr_ll", int'(cause_o), cz(2));
        step(45);

        // Reset mid-run.
        rst_i = 1'b1; step(2);
        chk("lit_rerst", int'(rst_n_o), 0);
        chk("lit_rerst_cause", int'(cause_o), cz(1));
        rst_i = 1'b0; step(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
